// File: rtl/usb_uart_byte_fifo_pkg.sv
// Shared defaults and sizing helper for the USB-to-UART byte FIFO.
package usb_uart_byte_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH_LOG2 = 6;

    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/usb_uart_byte_fifo_chk.sv
// Checker: flags any write accepted while the FIFO is already full.
module usb_uart_byte_fifo_chk #(
    parameter int DEPTH_LOG2 = 6
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  push,
    input logic [DEPTH_LOG2:0]   level
);

    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        !(push && (level == FULL_LEVEL)))
        else $error("push accepted while full");

endmodule

// File: rtl/usb_uart_fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module usb_uart_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_uart_byte_fifo.sv
// Elastic byte FIFO between the USB CDC OUT stream and the UART transmitter,
// first-word fall-through with registered outputs and a clearable high-water mark.
module usb_uart_byte_fifo
    import usb_uart_byte_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   max_level,
    input  logic                  clr_max
);

    localparam int                  DEPTH      = fifo_depth(DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d, max_q, max_d;
    logic                  tready_q, tready_d, tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d, ram_rdata;
    logic                  push, pop, bypass;

    usb_uart_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    usb_uart_byte_fifo_chk #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .level (level_q)
    );

    // next-state: pointers, level, flags, head data and high-water mark
    always_comb begin
        push     = s_axis_tvalid & tready_q;
        pop      = tvalid_q & m_axis_tready;
        wr_ptr_d = push ? (wr_ptr_q + (DEPTH_LOG2)'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + (DEPTH_LOG2)'(1)) : rd_ptr_q;
        level_d  = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        tready_d = (level_d != FULL_LEVEL);
        tvalid_d = (level_d != (DEPTH_LOG2+1)'(0));
        // new head is the byte being written this edge when nothing else remains
        bypass   = push && (level_q == (DEPTH_LOG2+1)'(pop));
        if (bypass) begin
            tdata_d = s_axis_tdata;
        end else if (tvalid_d) begin
            tdata_d = ram_rdata;
        end else begin
            tdata_d = tdata_q;
        end
        if (clr_max) begin
            max_d = level_d;
        end else if (level_d > max_q) begin
            max_d = level_d;
        end else begin
            max_d = max_q;
        end
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            max_q    <= '0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            max_q    <= max_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign level         = level_q;
    assign max_level     = max_q;

endmodule

// File: tb/tb_usb_uart_byte_fifo.sv
// Self-checking bench for usb_uart_byte_fifo at DEPTH=4: directed vector table,
// multi-cycle reset sequence, and random traffic against a queue model.
module tb_usb_uart_byte_fifo;

    localparam int DW    = 8;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [DL:0]   level;
    logic [DL:0]   max_level;
    logic          clr_max;

    int checks = 0;
    int errors = 0;

    usb_uart_byte_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .level         (level),
        .max_level     (max_level),
        .clr_max       (clr_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       clr;
        logic       e_tready;
        logic       e_tvalid;
        logic [7:0] e_tdata;
        int         e_level;
        int         e_max;
    } vec_t;

    vec_t vq[$];

    // reference model
    logic [7:0] q[$];
    int         max_m;
    bit         tready_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic sv, input logic [7:0] sd, input logic mr, input logic clr,
                       input logic et, input logic ev, input logic [7:0] ed, input int el, input int em);
        vec_t v;
        v = '{sv, sd, mr, clr, et, ev, ed, el, em};
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        m_tready = 1'b0;
        clr_max  = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        q.delete();
        max_m    = 0;
        tready_m = 1'b0;
        chk("rst_tready", {31'd0, s_tready}, 32'd0);
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_level",  {29'd0, level}, 32'd0);
        chk("rst_max",    {29'd0, max_level}, 32'd0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_tvalid"}, {31'd0, m_tvalid}, (q.size() != 0) ? 32'd1 : 32'd0);
        if (q.size() != 0) chk({tag, "_tdata"}, {24'd0, m_tdata}, {24'd0, q[0]});
        chk({tag, "_level"},  {29'd0, level}, q.size());
        chk({tag, "_tready"}, {31'd0, s_tready}, {31'd0, tready_m});
        chk({tag, "_max"},    {29'd0, max_level}, max_m);
    endtask

    // drive one cycle (called at negedge), advance model across the edge, return at next negedge
    task automatic step_model(input bit sv, input logic [7:0] sd, input bit mr, input bit clr);
        bit push, pop;
        push     = sv && tready_m;
        pop      = mr && (q.size() != 0);
        s_tvalid = sv;
        s_tdata  = sd;
        m_tready = mr;
        clr_max  = clr;
        @(posedge clk);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(sd);
        if (clr) max_m = q.size();
        else if (q.size() > max_m) max_m = q.size();
        tready_m = (q.size() != DEPTH);
        @(negedge clk);
    endtask

    initial begin
        // sv  sd     mr clr  tready tvalid tdata level max
        add(1, 8'h41, 0, 0,   1, 0, 8'h00, 0, 0);
        add(1, 8'h41, 0, 0,   1, 1, 8'h41, 1, 1);
        add(0, 8'h00, 1, 0,   1, 0, 8'h00, 0, 1);
        add(0, 8'h00, 0, 1,   1, 0, 8'h00, 0, 0);
        add(1, 8'h10, 0, 0,   1, 1, 8'h10, 1, 1);
        add(1, 8'h11, 0, 0,   1, 1, 8'h10, 2, 2);
        add(1, 8'h12, 0, 0,   1, 1, 8'h10, 3, 3);
        add(1, 8'h13, 0, 0,   0, 1, 8'h10, 4, 4);
        add(1, 8'h14, 0, 0,   0, 1, 8'h10, 4, 4);
        add(1, 8'h14, 1, 0,   1, 1, 8'h11, 3, 4);
        add(1, 8'h14, 0, 0,   0, 1, 8'h11, 4, 4);
        add(0, 8'h00, 1, 0,   1, 1, 8'h12, 3, 4);
        add(0, 8'h00, 1, 0,   1, 1, 8'h13, 2, 4);
        add(0, 8'h00, 1, 0,   1, 1, 8'h14, 1, 4);
        add(0, 8'h00, 1, 0,   1, 0, 8'h00, 0, 4);
        add(0, 8'h00, 0, 1,   1, 0, 8'h00, 0, 0);
        add(1, 8'ha0, 0, 0,   1, 1, 8'ha0, 1, 1);
        add(1, 8'ha1, 0, 0,   1, 1, 8'ha0, 2, 2);
        add(1, 8'ha2, 0, 0,   1, 1, 8'ha0, 3, 3);
        add(0, 8'h00, 1, 0,   1, 1, 8'ha1, 2, 3);
        add(0, 8'h00, 1, 0,   1, 1, 8'ha2, 1, 3);
        add(0, 8'h00, 1, 0,   1, 0, 8'h00, 0, 3);
        add(0, 8'h00, 0, 1,   1, 0, 8'h00, 0, 0);
        add(1, 8'hb0, 0, 0,   1, 1, 8'hb0, 1, 1);
        add(0, 8'h00, 1, 0,   1, 0, 8'h00, 0, 1);
        add(1, 8'hc0, 0, 1,   1, 1, 8'hc0, 1, 1);
        add(0, 8'h00, 1, 0,   1, 0, 8'h00, 0, 1);

        do_reset();
        foreach (vq[i]) begin
            s_tvalid = vq[i].sv;
            s_tdata  = vq[i].sd;
            m_tready = vq[i].mr;
            clr_max  = vq[i].clr;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_tready", i), {31'd0, s_tready}, {31'd0, vq[i].e_tready});
            chk($sformatf("vec%0d_tvalid", i), {31'd0, m_tvalid}, {31'd0, vq[i].e_tvalid});
            if (vq[i].e_tvalid)
                chk($sformatf("vec%0d_tdata", i), {24'd0, m_tdata}, {24'd0, vq[i].e_tdata});
            chk($sformatf("vec%0d_level", i), {29'd0, level}, vq[i].e_level);
            chk($sformatf("vec%0d_max", i), {29'd0, max_level}, vq[i].e_max);
        end

        // steady push & pop at level 2: level must hold, order preserved
        do_reset();
        step_model(1'b0, 8'h00, 1'b0, 1'b0);
        step_model(1'b1, 8'($urandom), 1'b0, 1'b0);
        step_model(1'b1, 8'($urandom), 1'b0, 1'b0);
        check_model("fill2");
        for (int n = 0; n < 1000; n++) begin
            step_model(1'b1, 8'($urandom), 1'b1, 1'b0);
            chk("stream_level", {29'd0, level}, 32'd2);
            check_model("stream");
        end

        // fully random traffic, including backpressure and clears
        for (int n = 0; n < 2000; n++) begin
            step_model($urandom_range(0, 99) < 55, 8'($urandom),
                       $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4);
            check_model("rand");
        end

        // asynchronous reset mid-stream with three bytes buffered
        do_reset();
        step_model(1'b1, 8'h51, 1'b0, 1'b0);
        step_model(1'b1, 8'h52, 1'b0, 1'b0);
        step_model(1'b1, 8'h53, 1'b0, 1'b0);
        step_model(1'b0, 8'h00, 1'b0, 1'b0);
        check_model("pre_rst");
        #2 rst = 1'b1;
        #1;
        chk("async_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("async_level",  {29'd0, level}, 32'd0);
        chk("async_tready", {31'd0, s_tready}, 32'd0);
        chk("async_max",    {29'd0, max_level}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        q.delete();
        max_m    = 0;
        tready_m = 1'b0;
        step_model(1'b0, 8'h00, 1'b1, 1'b0);
        check_model("post_rst");
        step_model(1'b1, 8'h61, 1'b0, 1'b0);
        check_model("post_rst_push");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
